// File: rtl/spi_cmd_sequencer.sv
// Command-queueing front end for the SPI master: buffers {byte, slave} commands,
// launches one transfer at a time and returns the received byte (or a watchdog error).
module spi_cmd_sequencer #(
  parameter  int NUM_SLAVES = 2,
  parameter  int DEPTH      = 4,
  parameter  int TIMEOUT    = 64,
  localparam int SW         = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [7:0]    cmd_data,
  input  logic [SW-1:0] cmd_slave,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [7:0]    rsp_data,
  output logic [SW-1:0] rsp_slave,
  output logic          rsp_err,
  output logic          m_start,
  output logic [7:0]    m_data_in,
  output logic [SW-1:0] m_slave_select,
  input  logic [7:0]    m_data_out,
  input  logic          m_done,
  output logic          busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef struct packed { logic [SW-1:0] slave; logic [7:0] data; } cmd_t;
  typedef struct packed { logic err; logic [SW-1:0] slave; logic [7:0] data; } rsp_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH} state_t;

  state_t        state, state_nx;
  logic          launch, rsp_push, rsp_pop, cmd_push, wdog_clr, wdog_exp;
  logic [WW-1:0] wdog;
  rsp_t          rsp_in, rsp_head;
  cmd_t          cmd_head;

  // command FIFO
  cmd_t          cmd_mem [DEPTH];
  logic [AW-1:0] cmd_wp, cmd_rp;
  logic [CW-1:0] cmd_cnt;

  assign cmd_ready = (cmd_cnt != CW'(DEPTH));
  assign cmd_push  = cmd_valid && cmd_ready;
  assign cmd_head  = cmd_mem[cmd_rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_wp  <= '0;
      cmd_rp  <= '0;
      cmd_cnt <= '0;
    end else begin
      if (cmd_push) cmd_wp <= cmd_wp + 1'b1;
      if (launch)   cmd_rp <= cmd_rp + 1'b1;
      cmd_cnt <= cmd_cnt + CW'(cmd_push) - CW'(launch);
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wp] <= {cmd_slave, cmd_data};
  end

  // response FIFO; storage is cleared so the head reads zero out of reset
  rsp_t          rsp_mem [DEPTH];
  logic [AW-1:0] rsp_wp, rsp_rp;
  logic [CW-1:0] rsp_cnt;

  assign rsp_valid = (rsp_cnt != '0);
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign rsp_head  = rsp_mem[rsp_rp];
  assign rsp_data  = rsp_head.data;
  assign rsp_slave = rsp_head.slave;
  assign rsp_err   = rsp_head.err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_wp  <= '0;
      rsp_rp  <= '0;
      rsp_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) rsp_mem[i] <= '0;
    end else begin
      if (rsp_push) begin
        rsp_mem[rsp_wp] <= rsp_in;
        rsp_wp          <= rsp_wp + 1'b1;
      end
      if (rsp_pop) rsp_rp <= rsp_rp + 1'b1;
      rsp_cnt <= rsp_cnt + CW'(rsp_push) - CW'(rsp_pop);
    end
  end

  // sequencer FSM; a launch needs a free response slot so the result can never be dropped
  assign wdog_exp = (wdog >= WW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    wdog_clr = 1'b0;
    rsp_push = 1'b0;
    rsp_in   = '{err: 1'b1, slave: m_slave_select, data: 8'h00};
    case (state)
      IDLE: begin
        if (cmd_cnt != '0 && rsp_cnt != CW'(DEPTH)) begin
          launch   = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        wdog_clr = 1'b1;
        state_nx = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!m_done) begin
          wdog_clr = 1'b1;
          state_nx = WAIT_HIGH;
        end else if (wdog_exp) begin
          rsp_push = 1'b1;
          state_nx = IDLE;
        end
      end
      WAIT_HIGH: begin
        if (m_done) begin
          rsp_push = 1'b1;
          rsp_in   = '{err: 1'b0, slave: m_slave_select, data: m_data_out};
          state_nx = IDLE;
        end else if (wdog_exp) begin
          rsp_push = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // watchdog: counts wait cycles, saturates at TIMEOUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    wdog <= '0;
    else if (wdog_clr)                          wdog <= '0;
    else if ((state == WAIT_LOW || state == WAIT_HIGH) &&
             wdog != WW'(TIMEOUT))              wdog <= wdog + 1'b1;
  end

  // master-side outputs; data/select hold the last launched command
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_start        <= 1'b0;
      m_data_in      <= '0;
      m_slave_select <= '0;
    end else begin
      m_start <= launch;
      if (launch) begin
        m_data_in      <= cmd_head.data;
        m_slave_select <= cmd_head.slave;
      end
    end
  end

  assign busy = (state != IDLE) || (cmd_cnt != '0);

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Randomized bench for spi_cmd_sequencer: behavioural SPI master (returns byte ^ 0x99)
// plus a queue-based scoreboard of expected launches and responses.
module tb_spi_cmd_sequencer;
  localparam int NUM_SLAVES = 2;
  localparam int DEPTH      = 4;
  localparam int TIMEOUT    = 64;
  localparam int SW         = 1;

  logic          clk = 1'b0, rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [7:0]    cmd_data = '0;
  logic [SW-1:0] cmd_slave = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [7:0]    rsp_data;
  logic [SW-1:0] rsp_slave;
  logic          rsp_err;
  logic          m_start;
  logic [7:0]    m_data_in;
  logic [SW-1:0] m_slave_select;
  logic [7:0]    m_data_out = '0;
  logic          m_done = 1'b1;
  logic          busy;

  spi_cmd_sequencer #(.NUM_SLAVES(NUM_SLAVES), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_slave(cmd_slave),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_slave(rsp_slave),
    .rsp_err(rsp_err), .m_start(m_start), .m_data_in(m_data_in), .m_slave_select(m_slave_select),
    .m_data_out(m_data_out), .m_done(m_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; logic [SW-1:0] slave; } cmd_e;
  typedef struct { logic [7:0] data; logic [SW-1:0] slave; logic err; } rsp_e;

  cmd_e lq[$];             // accepted, not yet launched
  rsp_e rq[$];             // launched, response not yet consumed
  int   n_tests = 0, n_fail = 0;
  int   n_launch = 0, n_pop = 0, cyc = 0, launch_cyc = 0, pop_cyc = 0;
  int   m_mode = 0;        // 0 normal, 1 done stuck high, 2 done stuck low
  bit   mbusy = 0;
  logic [7:0] last_data;
  logic [SW-1:0] last_slave;
  logic last_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_cmd_ready"}, 32'(cmd_ready), 1);
    chk({t, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({t, "_rsp_data"},  32'(rsp_data), 0);
    chk({t, "_rsp_slave"}, 32'(rsp_slave), 0);
    chk({t, "_rsp_err"},   32'(rsp_err), 0);
    chk({t, "_m_start"},   32'(m_start), 0);
    chk({t, "_m_data_in"}, 32'(m_data_in), 0);
    chk({t, "_m_sel"},     32'(m_slave_select), 0);
    chk({t, "_busy"},      32'(busy), 0);
  endtask

  task automatic send_cmd(input logic [7:0] d, input logic [SW-1:0] s);
    int n = 0;
    cmd_valid = 1'b1; cmd_data = d; cmd_slave = s;
    while (!cmd_ready && n < 1000) begin step(1); n++; end
    chk("cmd_accept_timeout", 32'(n < 1000), 1);
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string t, input int budget);
    int n = 0;
    rsp_ready = 1'b1;
    while ((lq.size() != 0 || rq.size() != 0 || mbusy) && n < budget) begin step(1); n++; end
    chk({t, "_drain_timeout"}, 32'(n < budget), 1);
    step(2);
    chk({t, "_busy_idle"}, 32'(busy), 0);
    chk({t, "_rsp_valid_idle"}, 32'(rsp_valid), 0);
  endtask

  // master model: drops done after a start, raises it with byte^0x99 some cycles later
  initial begin
    int mcnt = 0;
    logic [7:0] mlat = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        mbusy = 0; m_done = 1'b1;
      end else if (mbusy) begin
        if (mcnt > 0) mcnt--;
        if (mcnt == 0) begin mbusy = 0; m_done = 1'b1; m_data_out = mlat ^ 8'h99; end
        else m_data_out = 8'($urandom);
      end else if (m_start && m_mode != 1) begin
        mbusy = 1; mlat = m_data_in; m_done = 1'b0;
        mcnt = (m_mode == 2) ? TIMEOUT + 20 : $urandom_range(2, 7);
        m_data_out = 8'($urandom);
      end
    end
  end

  // scoreboard: launch order/content, credit, pulse width, cmd_ready, response order/content
  initial begin
    cmd_e e;
    rsp_e r;
    int mcmd = 0;
    bit prev_start = 0, last_pop = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        mcmd = 0; prev_start = 0; last_pop = 0;
      end else begin
        if (m_start) begin
          n_launch++; launch_cyc = cyc; mcmd--;
          chk("start_width", 32'(prev_start), 0);
          chk("credit", 32'(rq.size() + int'(last_pop) < DEPTH), 1);
          if (lq.size() == 0) chk("spurious_start", 1, 0);
          else begin
            e = lq.pop_front();
            chk("m_data_in", 32'(m_data_in), 32'(e.data));
            chk("m_slave_select", 32'(m_slave_select), 32'(e.slave));
            r.data  = (m_mode == 0) ? (e.data ^ 8'h99) : 8'h00;
            r.slave = e.slave;
            r.err   = (m_mode != 0);
            rq.push_back(r);
          end
        end
        prev_start = m_start;
        chk("cmd_ready", 32'(cmd_ready), 32'(mcmd < DEPTH));
        if (cmd_valid && cmd_ready) begin
          e.data = cmd_data; e.slave = cmd_slave;
          lq.push_back(e); mcmd++;
        end
        last_pop = rsp_valid && rsp_ready;
        if (rsp_valid && rsp_ready) begin
          n_pop++; pop_cyc = cyc;
          last_data = rsp_data; last_slave = rsp_slave; last_err = rsp_err;
          if (rq.size() == 0) chk("spurious_rsp", 1, 0);
          else begin
            r = rq.pop_front();
            chk("rsp_data", 32'(rsp_data), 32'(r.data));
            chk("rsp_slave", 32'(rsp_slave), 32'(r.slave));
            chk("rsp_err", 32'(rsp_err), 32'(r.err));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int b, p, n, lat;
    bit done_sends;
    step(3);
    chk_reset("reset");
    rst = 1'b0;
    step(2);

    // single command, loopback 0xA5 -> 0x3C
    b = n_launch;
    send_cmd(8'hA5, 1'b1);
    wait_idle("t1", 300);
    chk("t1_launches", 32'(n_launch - b), 1);
    chk("t1_data", 32'(last_data), 32'h3C);
    chk("t1_slave", 32'(last_slave), 1);
    chk("t1_err", 32'(last_err), 0);

    // burst with consumer stalled: exactly DEPTH launches, then credit stall
    rsp_ready = 1'b0;
    b = n_launch;
    for (int i = 0; i < 2 * DEPTH; i++) send_cmd(8'($urandom), SW'($urandom_range(0, NUM_SLAVES - 1)));
    step(40);
    chk("burst_launches", 32'(n_launch - b), DEPTH);
    chk("burst_cmd_full", 32'(cmd_ready), 0);
    chk("burst_busy", 32'(busy), 1);
    n = 0;
    while ((lq.size() != 0 || rq.size() != 0) && n < 2000) begin
      rsp_ready = 1'($urandom);
      step(1); n++;
    end
    wait_idle("burst", 300);
    chk("burst_total", 32'(n_launch - b), 2 * DEPTH);

    // done stuck high: WAIT_LOW timeout, then a normal transfer
    m_mode = 1;
    send_cmd(8'h5E, 1'b0);
    wait_idle("to_low", 400);
    lat = pop_cyc - launch_cyc;
    chk("to_low_latency", 32'(lat >= TIMEOUT && lat <= TIMEOUT + 4), 1);
    chk("to_low_err", 32'(last_err), 1);
    m_mode = 0;
    send_cmd(8'h81, 1'b1);
    wait_idle("to_low_next", 300);
    chk("to_low_next_data", 32'(last_data), 32'h18);

    // done stuck low: WAIT_HIGH timeout, then a normal transfer
    m_mode = 2;
    send_cmd(8'hC3, 1'b1);
    wait_idle("to_high", 400);
    lat = pop_cyc - launch_cyc;
    chk("to_high_latency", 32'(lat >= TIMEOUT && lat <= TIMEOUT + 4), 1);
    chk("to_high_err", 32'(last_err), 1);
    m_mode = 0;
    send_cmd(8'h66, 1'b0);
    wait_idle("to_high_next", 300);
    chk("to_high_next_data", 32'(last_data), 32'hFF);

    // push and pop on the response FIFO in the same cycle at count DEPTH-1
    rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) send_cmd(8'($urandom), SW'($urandom_range(0, NUM_SLAVES - 1)));
    n = 0;
    while ((lq.size() != 0 || mbusy || busy) && n < 300) begin step(1); n++; end
    chk("simul_fill_timeout", 32'(n < 300), 1);
    chk("simul_rsp_valid", 32'(rsp_valid), 1);
    send_cmd(8'h42, 1'b1);
    n = 0;
    while (m_done && n < 50) begin step(1); n++; end
    while (!m_done && n < 100) begin step(1); n++; end
    chk("simul_done_timeout", 32'(n < 100), 1);
    rsp_ready = 1'b1;
    step(1);
    rsp_ready = 1'b0;
    step(1);
    p = n_pop;
    wait_idle("simul", 300);
    chk("simul_remaining", 32'(n_pop - p), DEPTH - 1);

    // randomized traffic with a randomly stalling consumer
    done_sends = 0;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          step($urandom_range(0, 3));
          send_cmd(8'($urandom), SW'($urandom_range(0, NUM_SLAVES - 1)));
        end
        done_sends = 1;
      end
      begin
        while (!done_sends) begin rsp_ready = 1'($urandom); step(1); end
      end
    join
    wait_idle("rand", 1500);

    // reset while in WAIT_HIGH with two commands queued
    m_mode = 2;
    rsp_ready = 1'b1;
    b = n_launch;
    send_cmd(8'h11, 1'b1);
    send_cmd(8'h22, 1'b1);
    send_cmd(8'h33, 1'b1);
    n = 0;
    while (n_launch == b && n < 50) begin step(1); n++; end
    chk("rst_launch_timeout", 32'(n < 50), 1);
    step(5);
    chk("rst_pre_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk_reset("rst_mid");
    lq.delete();
    rq.delete();
    m_mode = 0;
    step(3);
    rst = 1'b0;
    b = n_launch; p = n_pop;
    step(30);
    chk("rst_no_start", 32'(n_launch - b), 0);
    chk("rst_no_rsp", 32'(n_pop - p), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_cmd_sequencer.md
# spi_cmd_sequencer

Command-queueing front end that sits directly upstream of the SPI master. It buffers byte-wide SPI commands (payload plus target slave) in a command FIFO and launches them one at a time on the master's start/data/select inputs. It waits for the master's done flag, captures the received byte, and returns it with its slave index through a response FIFO. A watchdog flags transfers whose done handshake never completes.

## Interface
- NUM_SLAVES, 2, number of chip selects on the downstream master; SW = max(1, $clog2(NUM_SLAVES))
- DEPTH, 4, entries in each of the command and response FIFOs; power of two, >= 2
- TIMEOUT, 64, max cycles spent waiting on one done phase before the watchdog fires; >= 32

- clk  in  1  system clock, shared with the SPI master
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command FIFO not full
- cmd_data  in  8  byte to transmit
- cmd_slave  in  SW  target slave index
- rsp_valid  out  1  response FIFO not empty
- rsp_ready  in  1  consumer takes head response
- rsp_data  out  8  received byte (0x00 on error)
- rsp_slave  out  SW  slave index of that transfer
- rsp_err  out  1  transfer ended by watchdog
- m_start  out  1  start pulse to master
- m_data_in  out  8  byte to master
- m_slave_select  out  SW  slave index to master
- m_data_out  in  8  master's received byte
- m_done  in  1  master done flag (low while busy; high when idle)
- busy  out  1  state != IDLE or command FIFO non-empty

## Operation
- Command push when cmd_valid && cmd_ready. Response pop when rsp_valid && rsp_ready. Both FIFOs are registered, with pointer wrap modulo DEPTH and a count of width $clog2(DEPTH)+1.
- Credit rule: a launch requires rsp_count + 1 <= DEPTH, so an in-flight transfer always has a response slot. Responses are never dropped.
- The FSM has four states:
  - IDLE: if the command FIFO is non-empty and credit is available, pop the head; register m_data_in/m_slave_select; set m_start=1; go to ISSUE.
  - ISSUE: m_start=0; clear the watchdog; go to WAIT_LOW.
  - WAIT_LOW: wait for m_done==0, then clear the watchdog and go to WAIT_HIGH. If the watchdog reaches TIMEOUT, push {err=1, data=0x00, slave} and go to IDLE.
  - WAIT_HIGH: on m_done==1, push {err=0, m_data_out, slave} and go to IDLE. If the watchdog reaches TIMEOUT, push an error response as in WAIT_LOW and go to IDLE.
- The watchdog counts one per cycle in WAIT_LOW/WAIT_HIGH and saturates.
- m_data_in and m_slave_select hold their last launched values between transfers.
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle: both occur; count unchanged. This is legal at full for the response FIFO only if the pop occurs; the credit rule guarantees no overflow.
  - Command FIFO full: cmd_ready=0; a pop in the same cycle does not enable a push that cycle.

## Timing
- Reset values:
  - Outputs: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_slave=0, rsp_err=0, m_start=0, m_data_in=0, m_slave_select=0, busy=0.
  - Internal: FIFOs empty, FSM=IDLE.
- Reset mid-transfer: all state is cleared immediately and queued commands are discarded. The master shares rst.
- Command accepted at edge N is visible in the FIFO count after N. m_start is high in the cycle after edge N+1 (earliest).
- m_start is exactly one cycle wide. m_data_in/m_slave_select are valid in the same cycle and stable until the next launch.
- Response pushed at the edge where m_done==1 is sampled in WAIT_HIGH. rsp_valid is high in the next cycle.
- Minimum gap: one IDLE cycle between a response push and the next m_start.
- cmd_ready, rsp_valid and busy derive from registered counts/state only, with no combinational path from the inputs.

## Test plan
- Single command 0xA5 to slave 1, with the master model looping MISO back as 0x3C:
  - m_start pulses once with m_data_in=0xA5 and m_slave_select=1.
  - Response {0x3C, slave 1, err 0}.
  - busy returns to 0.
- Burst of DEPTH+1 commands with rsp_ready=0:
  - cmd_ready drops after DEPTH accepted.
  - Exactly DEPTH launches occur, then the FSM stalls in IDLE on credit.
  - Raising rsp_ready drains the responses in order and the remaining command launches.
- m_done held high forever: after TIMEOUT cycles in WAIT_LOW, response {0x00, slave, err 1}; the next command launches normally.
- m_done stuck low after start: WAIT_HIGH times out with err=1. A later real transfer returns correct data.
- Assert rst while in WAIT_HIGH with 2 commands queued:
  - All outputs return to reset values at once.
  - No response appears.
  - No m_start after reset is released.
- Simultaneous push and pop on the response FIFO at count DEPTH-1: count stays DEPTH-1 and data order is preserved.
